// File: rtl/xc_packed_malu.sv
// rtl/xc_packed_malu.sv - multi-cycle packed add/sub/multiply unit with valid/ready handshake
// Lanes are unsigned; multiplies run shift-add over W/UNROLL cycles into 2W-bit lane accumulators.
module xc_packed_malu #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            valid,
   input  logic            flush,
   input  logic [1:0]      op,
   input  logic [1:0]      pw,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_MUL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic [1:0]        pw_q, pw_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_sum;
   logic [6:0]        ctr_q, ctr_d, lane_w;

   function automatic logic [XLEN-1:0] lane_addsub(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                   input logic sub, input logic [1:0] w);
      logic [XLEN-1:0] r;
      r = '0;
      case (w)
         2'd0: r = sub ? a - b : a + b;
         2'd1: for (int l = 0; l < XLEN/16; l++)
                  r[l*16 +: 16] = sub ? a[l*16 +: 16] - b[l*16 +: 16] : a[l*16 +: 16] + b[l*16 +: 16];
         2'd2: for (int l = 0; l < XLEN/8; l++)
                  r[l*8 +: 8] = sub ? a[l*8 +: 8] - b[l*8 +: 8] : a[l*8 +: 8] + b[l*8 +: 8];
         default: for (int l = 0; l < XLEN/4; l++)
                  r[l*4 +: 4] = sub ? a[l*4 +: 4] - b[l*4 +: 4] : a[l*4 +: 4] + b[l*4 +: 4];
      endcase
      return r;
   endfunction

   // Partial product for multiplier bit k of every lane, placed in each lane's 2W-bit field.
   function automatic logic [2*XLEN-1:0] mul_addend(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                    input logic [1:0] w_sel, input int k);
      logic [2*XLEN-1:0] p;
      int w, lsh, l, j;
      p   = '0;
      w   = XLEN >> w_sel;
      lsh = 5 - int'(w_sel);
      for (int i = 0; i < XLEN; i++) begin
         l = i >> lsh;
         j = i & (w - 1);
         if (k < w && a[i] && b[l*w + k])
            p[2*l*w + j + k] = 1'b1;
      end
      return p;
   endfunction

   function automatic logic [XLEN-1:0] lane_extract(input logic [2*XLEN-1:0] acc, input logic hi,
                                                    input logic [1:0] w);
      logic [XLEN-1:0] r;
      r = '0;
      case (w)
         2'd0: r = hi ? acc[XLEN +: XLEN] : acc[0 +: XLEN];
         2'd1: for (int l = 0; l < XLEN/16; l++)
                  r[l*16 +: 16] = hi ? acc[l*32 + 16 +: 16] : acc[l*32 +: 16];
         2'd2: for (int l = 0; l < XLEN/8; l++)
                  r[l*8 +: 8] = hi ? acc[l*16 + 8 +: 8] : acc[l*16 +: 8];
         default: for (int l = 0; l < XLEN/4; l++)
                  r[l*4 +: 4] = hi ? acc[l*8 + 4 +: 4] : acc[l*8 +: 4];
      endcase
      return r;
   endfunction

   // Lane products never exceed 2W bits, so a flat add cannot carry across lanes.
   always_comb begin
      acc_sum = acc_q;
      for (int u = 0; u < UNROLL; u++)
         acc_sum = acc_sum + mul_addend(a_q, b_q, pw_q, int'(ctr_q) + u);
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      pw_d     = pw_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      acc_d    = acc_q;
      ctr_d    = ctr_q;
      lane_w   = 7'(XLEN) >> pw_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (valid) begin
               sel_d   = op[0];
               pw_d    = pw;
               a_d     = rs1;
               b_d     = rs2;
               acc_d   = '0;
               ctr_d   = '0;
               state_d = op[1] ? S_MUL : S_ADD;
            end
            S_ADD: begin
               result_d = lane_addsub(a_q, b_q, sel_q, pw_q);
               state_d  = S_DONE;
            end
            S_MUL: if (ctr_q == lane_w) begin
               result_d = lane_extract(acc_q, sel_q, pw_q);
               state_d  = S_DONE;
            end else begin
               acc_d = acc_sum;
               ctr_d = ctr_q + 7'(UNROLL);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q  <= S_IDLE;
         sel_q    <= 1'b0;
         pw_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         acc_q    <= '0;
         ctr_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         pw_q     <= pw_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         acc_q    <= acc_d;
         ctr_q    <= ctr_d;
      end
   end

   assign ready  = (state_q == S_DONE);
   assign busy   = (state_q == S_ADD) || (state_q == S_MUL);
   assign result = result_q;

endmodule

// File: tb/tb_xc_packed_malu.sv
// tb/tb_xc_packed_malu.sv - directed self-checking bench for xc_packed_malu
// Latency is counted in rising edges from the accept edge (inclusive) to the edge that raises ready.
module tb_xc_packed_malu;

   logic        g_clk = 1'b0;
   logic        g_reset, valid, flush;
   logic [1:0]  op, pw;
   logic [31:0] rs1, rs2;
   logic        ready, busy;
   logic [31:0] result;

   int n_checks = 0;
   int n_fails  = 0;

   xc_packed_malu #(.XLEN(32), .UNROLL(1)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .flush(flush),
      .op(op), .pw(pw), .rs1(rs1), .rs2(rs2),
      .ready(ready), .result(result), .busy(busy)
   );

   always #5 g_clk = ~g_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   // Issue one request, scramble operands after accept, and check latency, result and single pulse.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
      int cycles;
      bit seen;
      cycles = 0;
      seen   = 0;
      valid = 1'b1; op = o; pw = w; rs1 = a; rs2 = b;
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      step();
      cycles = 1;
      check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      rs1 = ~a; rs2 = a ^ b; pw = ~w;
      for (int i = 0; i < 100; i++) begin
         if (ready) begin
            seen = 1;
            break;
         end
         step();
         cycles++;
      end
      check({tag, " ready_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
      check({tag, " result"}, result, exp);
      check({tag, " ready_busy_excl"}, 32'(busy), 32'd0);
      valid = 1'b0;
      step();
      check({tag, " ready_single"}, 32'(ready), 32'd0);
      check({tag, " result_held"}, result, exp);
   endtask

   initial begin
      int pulses;
      g_reset = 1'b1; valid = 1'b0; flush = 1'b0; op = 2'd0; pw = 2'd0; rs1 = '0; rs2 = '0;
      step();
      step();
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_result", result, 32'd0);
      g_reset = 1'b0;
      step();

      do_op("padd_2x16", 2'b00, 2'b01, 32'h0001FFFF, 32'h00010001, 32'h00020000, 2);
      do_op("psub_4x8", 2'b01, 2'b10, 32'h00000000, 32'h01010101, 32'hFFFFFFFF, 2);
      do_op("pmull_1x32", 2'b10, 2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 34);
      do_op("pmulh_4x8", 2'b11, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFEFEFEFE, 10);
      do_op("pmull_8x4", 2'b10, 2'b11, 32'h77777777, 32'h22222222, 32'hEEEEEEEE, 6);
      do_op("pmulh_1x32", 2'b11, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      do_op("pmull_2x16", 2'b10, 2'b01, 32'h00030005, 32'h00070009, 32'h0015002D, 18);
      do_op("pmulh_2x16", 2'b11, 2'b01, 32'h80000100, 32'h00020100, 32'h00010001, 18);
      do_op("psub_1x32", 2'b01, 2'b00, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 2);
      do_op("padd_8x4", 2'b00, 2'b11, 32'h88888888, 32'h88888888, 32'h00000000, 2);

      // Flush five cycles into a multiply.
      valid = 1'b1; op = 2'b10; pw = 2'b00; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
      for (int i = 0; i < 5; i++) step();
      check("flush_busy_before", 32'(busy), 32'd1);
      valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_ready", 32'(ready), 32'd0);
      check("flush_result", result, 32'h00000000);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready) pulses++;
         step();
      end
      check("flush_no_ready", 32'(pulses), 32'd0);
      do_op("padd_after_flush", 2'b00, 2'b00, 32'd1, 32'd2, 32'd3, 2);

      // flush together with valid in IDLE must not accept.
      valid = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
      step();
      valid = 1'b0; flush = 1'b0;
      check("flush_valid_busy", 32'(busy), 32'd0);
      step();
      check("flush_valid_ready", 32'(ready), 32'd0);

      // Reset during MUL.
      valid = 1'b1; op = 2'b11; pw = 2'b00; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) step();
      valid = 1'b0; g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      check("rst_mid_ready", 32'(ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_result", result, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready) pulses++;
         step();
      end
      check("rst_mid_no_ready", 32'(pulses), 32'd0);

      do_op("padd_b2b_a", 2'b00, 2'b10, 32'h01020304, 32'h10FF2030, 32'h11012334, 2);
      do_op("padd_b2b_b", 2'b00, 2'b01, 32'h7FFF8000, 32'h00018000, 32'h80000000, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
